// File: rtl/lm_sm_sequencer_pkg.sv
// LM/SM sequencer shared definitions: opcodes, NOP encoding,
// sequencer state encoding and a multiple-opcode helper.
package lm_sm_sequencer_pkg;

  localparam logic [3:0]  OP_LM  = 4'b0110;
  localparam logic [3:0]  OP_SM  = 4'b0111;
  localparam logic [15:0] IR_NOP = 16'hF000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  function automatic logic is_multiple(
    input logic [15:0] ir
  );
    return (ir[15:12] == OP_LM) ||
           (ir[15:12] == OP_SM);
  endfunction

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// Decode-side bundle of the LM/SM sequencer.
// master: pipeline driving IR/stall/flush; slave: the sequencer.
interface lm_sm_sequencer_if;

  logic [15:0] IR_in;
  logic        stall_in;
  logic        flush;
  logic [15:0] IR_out;
  logic [2:0]  reg_idx;
  logic        first_multiple;
  logic        last_multiple;
  logic        write_inhibit;
  logic        stall_up;
  logic        modify_ir;

  modport master (
    output IR_in, stall_in, flush,
    input  IR_out, reg_idx,
    input  first_multiple, last_multiple,
    input  write_inhibit, stall_up, modify_ir
  );

  modport slave (
    input  IR_in, stall_in, flush,
    output IR_out, reg_idx,
    output first_multiple, last_multiple,
    output write_inhibit, stall_up, modify_ir
  );

endinterface

// File: rtl/lm_sm_sequencer_lsb_encode8.sv
// Lowest-set-bit encoder: mask_i -> idx_o (0 when empty),
// valid_o = mask non-zero.
module lsb_encode8 (
  input  logic [7:0] mask_i,
  output logic [2:0] idx_o,
  output logic       valid_o
);

  always_comb begin
    idx_o = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_i[i]) idx_o = 3'(i);
    end
  end

  assign valid_o = |mask_i;

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: expands a register-list instruction into one
// transfer per set bit. Ports: clk, reset, bus (slave modport).
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  lm_sm_sequencer_if.slave   bus
);

  seq_state_e  state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] ir_hold_q, ir_hold_d;

  logic        run;
  logic [7:0]  mask;
  logic [7:0]  rest;
  logic [15:0] ir_cur;
  logic [15:0] ir_eff;
  logic        mult;
  logic [2:0]  idx;
  logic        valid;

  assign run    = (state_q == ST_RUN);
  assign mask   = run ? rem_q : bus.IR_in[7:0];
  assign ir_cur = run ? ir_hold_q : bus.IR_in;
  // A flushed slot is a NOP, which clears
  // every multiple-related output at once.
  assign ir_eff = bus.flush ? IR_NOP : ir_cur;
  assign mult   = is_multiple(ir_eff);
  // Mask with its lowest bit dropped:
  // non-zero means two or more bits remain.
  assign rest   = mask & (mask - 8'd1);

  lsb_encode8 u_enc (
    .mask_i  (mask),
    .idx_o   (idx),
    .valid_o (valid)
  );

  assign bus.IR_out         = ir_eff;
  assign bus.reg_idx        = idx;
  assign bus.first_multiple = mult & ~run;
  assign bus.last_multiple  = mult & (rest == 8'd0);
  assign bus.stall_up       = mult & (rest != 8'd0);
  assign bus.modify_ir      = mult;
  assign bus.write_inhibit  = bus.flush | (mult & ~valid);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    ir_hold_d = ir_hold_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      rem_d   = 8'd0;
    end else if (!bus.stall_in) begin
      if (mult && rest != 8'd0) begin
        state_d   = ST_RUN;
        rem_d     = rest;
        ir_hold_d = ir_eff;
      end else begin
        state_d = ST_IDLE;
        rem_d   = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= 8'd0;
      ir_hold_q <= IR_NOP;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      ir_hold_q <= ir_hold_d;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: directed scenarios plus random
// traffic against a queue-based transfer model.
module tb_lm_sm_sequencer;

  logic clk = 1'b0;
  logic reset;

  lm_sm_sequencer_if bus ();

  lm_sm_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          q[$];
  logic [15:0] m_hold;

  logic [15:0] g_ir;
  logic [2:0]  g_idx;
  logic        g_first, g_last;
  logic        g_wi, g_su, g_mod;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic capture();
    g_ir    = bus.IR_out;
    g_idx   = bus.reg_idx;
    g_first = bus.first_multiple;
    g_last  = bus.last_multiple;
    g_wi    = bus.write_inhibit;
    g_su    = bus.stall_up;
    g_mod   = bus.modify_ir;
  endtask

  task automatic step(
    input logic [15:0] ir,
    input logic        st,
    input logic        fl
  );
    int          lst[$];
    bit          mult;
    int          n;
    logic [15:0] e_ir;
    int          e_idx;
    bit          e_f, e_l, e_w, e_s, e_m;
    @(negedge clk);
    bus.IR_in    = ir;
    bus.stall_in = st;
    bus.flush    = fl;
    #1;
    capture();
    if (q.size() == 0) begin
      mult = (ir[15:12] == 4'd6) ||
             (ir[15:12] == 4'd7);
      for (int k = 0; k < 8; k++)
        if (ir[k]) lst.push_back(k);
      n     = lst.size();
      e_ir  = ir;
      e_idx = (n > 0) ? lst[0] : 0;
      e_f   = mult;
    end else begin
      mult  = 1'b1;
      n     = q.size();
      e_ir  = m_hold;
      e_idx = q[0];
      e_f   = 1'b0;
    end
    e_l = mult && (n <= 1);
    e_s = mult && (n >= 2);
    e_w = mult && (n == 0);
    e_m = mult;
    if (fl) begin
      e_ir = 16'hF000;
      e_f = 0; e_l = 0; e_s = 0;
      e_w = 1; e_m = 0;
    end else begin
      check("reg_idx", g_idx, e_idx);
    end
    check("IR_out", g_ir, e_ir);
    check("first", g_first, e_f);
    check("last", g_last, e_l);
    check("stall_up", g_su, e_s);
    check("wr_inh", g_wi, e_w);
    check("mod_ir", g_mod, e_m);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else if (!st) begin
      if (q.size() == 0) begin
        if (mult && lst.size() >= 2) begin
          q = lst[1:$];
          m_hold = ir;
        end
      end else begin
        void'(q.pop_front());
      end
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    bus.IR_in    = 16'hF000;
    bus.stall_in = 1'b0;
    bus.flush    = 1'b0;
    reset        = 1'b1;
    #1;
    capture();
    check("rst_ir", g_ir, 16'hF000);
    check("rst_su", g_su, 0);
    check("rst_first", g_first, 0);
    check("rst_last", g_last, 0);
    check("rst_mod", g_mod, 0);
    check("rst_idx", g_idx, 0);
    q.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rand_ir();
    logic [15:0] ir;
    logic [3:0]  op;
    ir = 16'($urandom);
    if ($urandom_range(0, 9) < 5) begin
      ir[15:12] = 4'b0110 |
                  4'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: ir[7:0] = 8'h00;
        1: ir[7:0] = 8'hFF;
        2: ir[7:0] = 8'h01 << $urandom_range(0, 7);
        default: ;
      endcase
    end else begin
      op = ir[15:12];
      if (op == 4'd6 || op == 4'd7) op ^= 4'b1000;
      ir[15:12] = op;
    end
    return ir;
  endfunction

  localparam logic [15:0] ADD = 16'h1234;

  initial begin
    reset        = 1'b1;
    bus.IR_in    = 16'hF000;
    bus.stall_in = 1'b0;
    bus.flush    = 1'b0;
    #3;
    capture();
    check("init_ir", g_ir, 16'hF000);
    check("init_first", g_first, 0);
    check("init_last", g_last, 0);
    check("init_su", g_su, 0);
    check("init_mod", g_mod, 0);
    check("init_idx", g_idx, 0);
    @(negedge clk);
    reset = 1'b0;

    // LM R2, list A5: 0,2,5,7
    step(16'h64A5, 0, 0);
    check("a5_idx0", g_idx, 0);
    check("a5_f0", g_first, 1);
    check("a5_su0", g_su, 1);
    step(16'h64A5, 0, 0);
    check("a5_idx1", g_idx, 2);
    check("a5_f1", g_first, 0);
    step(16'h64A5, 0, 0);
    check("a5_idx2", g_idx, 5);
    check("a5_l2", g_last, 0);
    step(16'h64A5, 0, 0);
    check("a5_idx3", g_idx, 7);
    check("a5_l3", g_last, 1);
    check("a5_su3", g_su, 0);
    step(ADD, 0, 0);
    check("a5_done", g_ir, ADD);

    // SM with empty list
    step(16'h7000, 0, 0);
    check("sm0_wi", g_wi, 1);
    check("sm0_last", g_last, 1);
    check("sm0_su", g_su, 0);
    step(ADD, 0, 0);
    check("sm0_idle", g_mod, 0);

    // LM FF with a 3-cycle stall on transfer 2
    step(16'h60FF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(16'h60FF, 1, 0);
      check("ff_hold", g_idx, 1);
    end
    for (int i = 1; i < 8; i++) begin
      step(16'h60FF, 0, 0);
      check("ff_idx", g_idx, i);
    end
    check("ff_last", g_last, 1);
    step(ADD, 0, 0);
    check("ff_idle", g_ir, ADD);

    // LM 0F flushed on cycle 2
    step(16'h600F, 0, 0);
    step(16'h600F, 0, 1);
    check("fl_ir", g_ir, 16'hF000);
    step(ADD, 0, 0);
    check("fl_acc", g_ir, ADD);
    check("fl_first", g_first, 0);

    // Reset mid-sequence with rem = 30
    step(16'h6038, 0, 0);
    check("r_idx", g_idx, 3);
    async_reset();
    step(16'h6081, 0, 0);
    check("r_fresh", g_first, 1);
    step(16'h6081, 0, 0);
    check("r_fresh7", g_idx, 7);

    // ADD then LM with single register R7
    step(ADD, 0, 0);
    check("add_mod", g_mod, 0);
    step(16'h6080, 0, 0);
    check("r7_idx", g_idx, 7);
    check("r7_first", g_first, 1);
    check("r7_last", g_last, 1);
    check("r7_su", g_su, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0)
        async_reset();
      else
        step(rand_ir(),
             $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 8);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 The block SHALL have these ports: reset, input, 1, asynchronous, active-high.
REQ-003 The block SHALL have these ports: IR_in, input, 16, instruction from the fetch/decode pipeline register.
REQ-004 The block SHALL have these ports: stall_in, input, 1, downstream hold; freezes sequencer state.
REQ-005 The block SHALL have these ports: flush, input, 1, squash of the instruction in decode.
REQ-006 The block SHALL have these ports: IR_out, output, 16, instruction presented to the next pipeline register.
REQ-007 The block SHALL have these ports: reg_idx, output, 3, register number for the current transfer.
REQ-008 The block SHALL have these ports: first_multiple, output, 1, first transfer of an LM/SM.
REQ-009 The block SHALL have these ports: last_multiple, output, 1, final transfer of an LM/SM.
REQ-010 The block SHALL have these ports: write_inhibit, output, 1, transfer is a NOP (empty list or flushed).
REQ-011 The block SHALL have these ports: stall_up, output, 1, hold PC and the upstream pipeline register this cycle.
REQ-012 The block SHALL have these ports: modify_ir, output, 1, next stage replaces IR[11:9] with reg_idx.

Function
REQ-013 Multiple instructions SHALL be opcode IR[15:12] = LM (0110) or SM (0111), with register list IR[7:0] where bit k selects Rk.
REQ-014 The block SHALL have two states, IDLE and RUN, plus an 8-bit remaining mask (rem) and a 16-bit held IR (ir_hold).
REQ-015 The active mask SHALL be IR_in[7:0] in IDLE and rem in RUN; reg_idx SHALL be the index of its lowest set bit, and 0 when the mask is zero.
REQ-016 IR_out SHALL be IR_in in IDLE and ir_hold in RUN; flush=1 SHALL force IR_out = 16'hF000.
REQ-017 In IDLE with a multiple opcode, first_multiple SHALL be 1; in RUN it SHALL be 0.
REQ-018 last_multiple SHALL be 1 when the active mask has at most one set bit and the instruction is a multiple.
REQ-019 stall_up SHALL be 1 when the instruction is a multiple and the active mask has two or more set bits; otherwise 0.
REQ-020 modify_ir SHALL be 1 for every cycle of a multiple instruction, including the empty-list case.
REQ-021 On a rising edge with stall_in=0 and flush=0: if the active mask with its lowest bit cleared is nonzero, the block SHALL go to RUN, load rem with that value and load ir_hold with IR_out; otherwise it SHALL go to IDLE.
REQ-022 An LM/SM with N set bits (N of 1 to 8) SHALL occupy exactly N unstalled cycles, issuing registers in ascending order.
REQ-023 An LM/SM with an empty list SHALL occupy one cycle with write_inhibit=1, last_multiple=1 and stall_up=0.
REQ-024 With stall_in=1, state, rem and ir_hold SHALL hold, and all outputs SHALL remain stable.
REQ-025 flush=1 SHALL take priority over stall_in: on the next edge the block SHALL enter IDLE and clear rem; that cycle SHALL have write_inhibit=1, stall_up=0, first_multiple=0 and modify_ir=0.
REQ-026 For non-multiple opcodes, first_multiple, last_multiple, stall_up and modify_ir SHALL be 0, and write_inhibit SHALL equal flush.

Reset
REQ-027 Reset assertion SHALL immediately force IDLE, rem=8'h00 and ir_hold=16'hF000, regardless of clk.
REQ-028 Reset asserted mid-sequence SHALL abandon the remaining transfers; after release, IR_in SHALL be decoded afresh.
REQ-029 While in reset with IR_in = 16'hF000, all 1-bit outputs SHALL be 0 except write_inhibit, reg_idx SHALL be 0, and IR_out SHALL be 16'hF000.

Structure
REQ-030 Opcodes LM/SM, the NOP encoding 16'hF000 and the state encoding SHALL live in the shared processor package.
REQ-031 Lowest-set-bit encoding SHALL be a sub-module, lsb_encode8, with an 8-bit input, a 3-bit index output and a 1-bit valid output; it SHALL be used for both IDLE and RUN masks.

Verification
REQ-032 Issue LM R2 with list 8'b1010_0101 -> reg_idx sequence 0, 2, 5, 7 over 4 cycles, with first_multiple only on cycle 1, last_multiple only on cycle 4, and stall_up = 1, 1, 1, 0.
REQ-033 Issue SM with list 8'h00 -> one cycle with write_inhibit=1, last_multiple=1 and stall_up=0, then IDLE.
REQ-034 Issue LM with list 8'hFF and stall_in=1 for 3 cycles after transfer 2 -> reg_idx holds at 1 during the stall, and the total sequence is 8 unstalled cycles.
REQ-035 Issue LM with list 8'h0F and flush on cycle 2 -> IR_out = 16'hF000 on that cycle, IDLE on the next, and IR_in is accepted the following cycle.
REQ-036 Assert reset between clock edges during RUN with rem = 8'h30 -> state is IDLE, IR_out = 16'hF000 and stall_up = 0 with no clock edge.
REQ-037 Issue ADD, then LM with list 8'h80 -> ADD passes with modify_ir=0; the LM produces a single cycle with reg_idx=7, first_multiple=1, last_multiple=1 and stall_up=0.
